// File: rtl/gbf_fill_ctrl.sv
// Upstream fill stage for one GBF bank pair: latches refill requests from the
// GBF controller, streams valid/ready words into port A of bank 1 or 2, and
// reports completed fills back through the per-bank ready flags.
module gbf_fill_ctrl #(
   parameter int unsigned GBF_DATA_BITWIDTH = 256,
   parameter int unsigned GBF_ADDR_BITWIDTH = 5,
   parameter int unsigned GBF_DEPTH         = 32
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         finish,
   input  logic [GBF_ADDR_BITWIDTH:0]   fill_words,
   input  logic                         in_valid,
   input  logic [GBF_DATA_BITWIDTH-1:0] in_data,
   output logic                         in_ready,
   input  logic                         gbf1_need_data,
   input  logic                         gbf2_need_data,
   output logic                         en1a,
   output logic                         we1a,
   output logic [GBF_ADDR_BITWIDTH-1:0] addr1a,
   output logic [GBF_DATA_BITWIDTH-1:0] w_data1a,
   output logic                         en2a,
   output logic                         we2a,
   output logic [GBF_ADDR_BITWIDTH-1:0] addr2a,
   output logic [GBF_DATA_BITWIDTH-1:0] w_data2a,
   output logic                         gbf_buf1_ready,
   output logic                         gbf_buf2_ready,
   output logic                         gbf_data_avail,
   output logic                         fill_busy
);

   localparam int unsigned CW = GBF_ADDR_BITWIDTH + 1;
   localparam logic [CW-1:0] DepthW = CW'(GBF_DEPTH);

   typedef enum logic [2:0] {StIdle, StFill1, StFill2, StDone1, StDone2} state_e;

   state_e                       state_q, state_d;
   logic [CW-1:0]                cnt_q, cnt_d, len_q, len_d, len_eff;
   logic                         pend1_q, pend1_d, pend2_q, pend2_d;
   logic                         need_prev1_q, need_prev1_d, need_prev2_q, need_prev2_d;
   logic                         ready1_q, ready1_d, ready2_q, ready2_d, avail_q, avail_d;
   logic                         en1_q, en1_d, we1_q, we1_d, en2_q, en2_d, we2_q, we2_d;
   logic [GBF_ADDR_BITWIDTH-1:0] addr1_q, addr1_d, addr2_q, addr2_d;
   logic [GBF_DATA_BITWIDTH-1:0] wdata1_q, wdata1_d, wdata2_q, wdata2_d;
   logic                         accept, last_beat;

   // Out-of-range fill lengths (0 or beyond the bank) mean "fill the whole bank".
   assign len_eff   = (fill_words == '0 || fill_words > DepthW) ? DepthW : fill_words;
   assign in_ready  = (state_q == StFill1) || (state_q == StFill2);
   assign fill_busy = (state_q != StIdle);
   assign accept    = in_valid && in_ready;
   assign last_beat = (cnt_q == len_q - 1'b1);

   // Next-state, request latch and registered port-A strobes.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      len_d        = len_q;
      pend1_d      = pend1_q;
      pend2_d      = pend2_q;
      need_prev1_d = gbf1_need_data;
      need_prev2_d = gbf2_need_data;
      ready1_d     = ready1_q;
      ready2_d     = ready2_q;
      avail_d      = avail_q;
      en1_d        = 1'b0;
      we1_d        = 1'b0;
      en2_d        = 1'b0;
      we2_d        = 1'b0;
      addr1_d      = addr1_q;
      addr2_d      = addr2_q;
      wdata1_d     = wdata1_q;
      wdata2_d     = wdata2_q;

      unique case (state_q)
         StIdle: begin
            if (pend1_q) begin
               state_d = StFill1;
               pend1_d = 1'b0;
               len_d   = len_eff;
               cnt_d   = '0;
            end else if (pend2_q) begin
               state_d = StFill2;
               pend2_d = 1'b0;
               len_d   = len_eff;
               cnt_d   = '0;
            end
         end
         StFill1: begin
            if (accept) begin
               en1_d    = 1'b1;
               we1_d    = 1'b1;
               addr1_d  = cnt_q[GBF_ADDR_BITWIDTH-1:0];
               wdata1_d = in_data;
               cnt_d    = cnt_q + 1'b1;
               if (last_beat) state_d = StDone1;
            end
         end
         StFill2: begin
            if (accept) begin
               en2_d    = 1'b1;
               we2_d    = 1'b1;
               addr2_d  = cnt_q[GBF_ADDR_BITWIDTH-1:0];
               wdata2_d = in_data;
               cnt_d    = cnt_q + 1'b1;
               if (last_beat) state_d = StDone2;
            end
         end
         StDone1: begin
            state_d  = StIdle;
            ready1_d = 1'b1;
            avail_d  = 1'b1;
         end
         StDone2: begin
            state_d  = StIdle;
            ready2_d = 1'b1;
            avail_d  = 1'b1;
         end
         default: state_d = StIdle;
      endcase

      // A fresh request overrides both the IDLE clear and a same-edge completion.
      if (gbf1_need_data && !need_prev1_q) begin
         pend1_d  = 1'b1;
         ready1_d = 1'b0;
      end
      if (gbf2_need_data && !need_prev2_q) begin
         pend2_d  = 1'b1;
         ready2_d = 1'b0;
      end

      // Layer done: drop everything except the need edge trackers.
      if (finish) begin
         state_d  = StIdle;
         pend1_d  = 1'b0;
         pend2_d  = 1'b0;
         ready1_d = 1'b0;
         ready2_d = 1'b0;
         avail_d  = 1'b0;
         en1_d    = 1'b0;
         we1_d    = 1'b0;
         en2_d    = 1'b0;
         we2_d    = 1'b0;
      end
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         len_q        <= '0;
         pend1_q      <= 1'b0;
         pend2_q      <= 1'b0;
         need_prev1_q <= 1'b0;
         need_prev2_q <= 1'b0;
         ready1_q     <= 1'b0;
         ready2_q     <= 1'b0;
         avail_q      <= 1'b0;
         en1_q        <= 1'b0;
         we1_q        <= 1'b0;
         en2_q        <= 1'b0;
         we2_q        <= 1'b0;
         addr1_q      <= '0;
         addr2_q      <= '0;
         wdata1_q     <= '0;
         wdata2_q     <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         len_q        <= len_d;
         pend1_q      <= pend1_d;
         pend2_q      <= pend2_d;
         need_prev1_q <= need_prev1_d;
         need_prev2_q <= need_prev2_d;
         ready1_q     <= ready1_d;
         ready2_q     <= ready2_d;
         avail_q      <= avail_d;
         en1_q        <= en1_d;
         we1_q        <= we1_d;
         en2_q        <= en2_d;
         we2_q        <= we2_d;
         addr1_q      <= addr1_d;
         addr2_q      <= addr2_d;
         wdata1_q     <= wdata1_d;
         wdata2_q     <= wdata2_d;
      end
   end

   assign en1a           = en1_q;
   assign we1a           = we1_q;
   assign addr1a         = addr1_q;
   assign w_data1a       = wdata1_q;
   assign en2a           = en2_q;
   assign we2a           = we2_q;
   assign addr2a         = addr2_q;
   assign w_data2a       = wdata2_q;
   assign gbf_buf1_ready = ready1_q;
   assign gbf_buf2_ready = ready2_q;
   assign gbf_data_avail = avail_q;

endmodule

// File: tb/tb_gbf_fill_ctrl.sv
// Bench for gbf_fill_ctrl: scenario tasks drive requests and word streams, and
// compare port-A writes and status flags against a request/fill model kept here.
module tb_gbf_fill_ctrl;

   localparam int DW = 256;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          reset, finish, in_valid, in_ready;
   logic [AW:0]   fill_words;
   logic [DW-1:0] in_data;
   logic          gbf1_need_data, gbf2_need_data;
   logic          en1a, we1a, en2a, we2a;
   logic [AW-1:0] addr1a, addr2a;
   logic [DW-1:0] w_data1a, w_data2a;
   logic          gbf_buf1_ready, gbf_buf2_ready, gbf_data_avail, fill_busy;

   int checks = 0;
   int errors = 0;
   // Model of the externally visible status flags.
   logic m_ready1 = 1'b0, m_ready2 = 1'b0, m_avail = 1'b0;

   gbf_fill_ctrl #(.GBF_DATA_BITWIDTH(DW), .GBF_ADDR_BITWIDTH(AW), .GBF_DEPTH(32)) dut (
      .clk(clk), .reset(reset), .finish(finish), .fill_words(fill_words),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .gbf1_need_data(gbf1_need_data), .gbf2_need_data(gbf2_need_data),
      .en1a(en1a), .we1a(we1a), .addr1a(addr1a), .w_data1a(w_data1a),
      .en2a(en2a), .we2a(we2a), .addr2a(addr2a), .w_data2a(w_data2a),
      .gbf_buf1_ready(gbf_buf1_ready), .gbf_buf2_ready(gbf_buf2_ready),
      .gbf_data_avail(gbf_data_avail), .fill_busy(fill_busy)
   );

   always #5 clk = ~clk;

   // Runs one fill of bank 'bank' that is already in progress at the current negedge.
   // mode 0: continuous valid, 1: toggling 1,0,1,0, 2: random valid and data.
   // inject >= 0 pulses gbf1_need_data at that cycle of the fill.
   task automatic do_fill(input int bank, input int len, input int mode, input int base,
                          input int inject);
      int idx = 0;
      int cyc = 0;
      logic pw = 1'b0;
      logic inj = 1'b0;
      logic v;
      logic [AW-1:0] pa = '0;
      logic [DW-1:0] pd = '0;
      while (idx < len && cyc < 400) begin
         checks++;
         if ((bank == 1 && pw) ? !(en1a === 1 && we1a === 1 && addr1a === pa &&
                                   w_data1a === pd && en2a === 0 && we2a === 0) :
             (bank == 2 && pw) ? !(en2a === 1 && we2a === 1 && addr2a === pa &&
                                   w_data2a === pd && en1a === 0 && we1a === 0) :
             !(en1a === 0 && we1a === 0 && en2a === 0 && we2a === 0)) begin
            errors++;
            $display("FAIL fill_write bank%0d cyc%0d: got en1/we1/a1=%b%b%0d en2/we2/a2=%b%b%0d, want write=%b addr=%0d",
                     bank, cyc, en1a, we1a, addr1a, en2a, we2a, addr2a, pw, pa);
         end
         checks++;
         if (in_ready !== 1'b1 || fill_busy !== 1'b1) begin
            errors++;
            $display("FAIL fill_ready bank%0d cyc%0d: got in_ready=%b busy=%b, want 1 1",
                     bank, cyc, in_ready, fill_busy);
         end
         checks++;
         if (gbf_buf1_ready !== m_ready1 || gbf_buf2_ready !== m_ready2 ||
             gbf_data_avail !== m_avail) begin
            errors++;
            $display("FAIL fill_flags bank%0d cyc%0d: got r1=%b r2=%b av=%b, want %b %b %b",
                     bank, cyc, gbf_buf1_ready, gbf_buf2_ready, gbf_data_avail,
                     m_ready1, m_ready2, m_avail);
         end
         if (cyc == inject) begin
            gbf1_need_data = 1'b1;
            inj = 1'b1;
         end
         v = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
         in_valid = v;
         if (mode == 2) in_data = {$urandom, $urandom, $urandom, $urandom,
                                   $urandom, $urandom, $urandom, $urandom};
         else in_data = DW'(base + idx);
         pw = v;
         if (v) begin
            pa = AW'(idx);
            pd = in_data;
            idx++;
         end
         @(negedge clk);
         cyc++;
         if (inj) begin
            m_ready1 = 1'b0;
            gbf1_need_data = 1'b0;
            inj = 1'b0;
         end
      end
      checks++;
      if (idx < len) begin
         errors++;
         $display("FAIL fill_timeout bank%0d: got %0d beats, want %0d", bank, idx, len);
      end
      // DONE cycle: last strobe visible, stream closed.
      in_valid = 1'($urandom_range(0, 1));
      checks++;
      if ((bank == 1) ? !(en1a === 1 && we1a === 1 && addr1a === pa && w_data1a === pd) :
                        !(en2a === 1 && we2a === 1 && addr2a === pa && w_data2a === pd)) begin
         errors++;
         $display("FAIL done_last_write bank%0d: got addr1=%0d addr2=%0d, want addr %0d",
                  bank, addr1a, addr2a, pa);
      end
      checks++;
      if (in_ready !== 1'b0 || fill_busy !== 1'b1 || gbf_buf1_ready !== m_ready1 ||
          gbf_buf2_ready !== m_ready2) begin
         errors++;
         $display("FAIL done_state bank%0d: got in_ready=%b busy=%b r1=%b r2=%b, want 0 1 %b %b",
                  bank, in_ready, fill_busy, gbf_buf1_ready, gbf_buf2_ready, m_ready1, m_ready2);
      end
      @(negedge clk);
      if (bank == 1) m_ready1 = 1'b1;
      else m_ready2 = 1'b1;
      m_avail = 1'b1;
      checks++;
      if (en1a !== 0 || we1a !== 0 || en2a !== 0 || we2a !== 0 || in_ready !== 0 ||
          fill_busy !== 0 || gbf_buf1_ready !== m_ready1 || gbf_buf2_ready !== m_ready2 ||
          gbf_data_avail !== 1'b1) begin
         errors++;
         $display("FAIL idle_after_fill bank%0d: got we=%b%b rdy=%b busy=%b r=%b%b av=%b, want 00 0 0 %b%b 1",
                  bank, we1a, we2a, in_ready, fill_busy, gbf_buf1_ready, gbf_buf2_ready,
                  gbf_data_avail, m_ready1, m_ready2);
      end
      in_valid = 1'b0;
   endtask

   // Pulses a need line; returns at the negedge where the fill has just started.
   task automatic request(input int bank);
      if (bank == 1) gbf1_need_data = 1'b1;
      else gbf2_need_data = 1'b1;
      @(negedge clk);
      if (bank == 1) m_ready1 = 1'b0;
      else m_ready2 = 1'b0;
      checks++;
      if (in_ready !== 1'b0 || fill_busy !== 1'b0 || gbf_buf1_ready !== m_ready1 ||
          gbf_buf2_ready !== m_ready2) begin
         errors++;
         $display("FAIL request_latch bank%0d: got in_ready=%b busy=%b r1=%b r2=%b, want 0 0 %b %b",
                  bank, in_ready, fill_busy, gbf_buf1_ready, gbf_buf2_ready, m_ready1, m_ready2);
      end
      gbf1_need_data = 1'b0;
      gbf2_need_data = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset;
      reset = 1'b1; finish = 1'b0; in_valid = 1'b0; in_data = '0;
      fill_words = 6'd32; gbf1_need_data = 1'b1; gbf2_need_data = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (in_ready !== 0 || en1a !== 0 || we1a !== 0 || addr1a !== '0 || w_data1a !== '0 ||
          en2a !== 0 || we2a !== 0 || addr2a !== '0 || w_data2a !== '0 ||
          gbf_buf1_ready !== 0 || gbf_buf2_ready !== 0 || gbf_data_avail !== 0 ||
          fill_busy !== 0) begin
         errors++;
         $display("FAIL reset_outputs: got rdy=%b we=%b%b r=%b%b av=%b busy=%b, want all 0",
                  in_ready, we1a, we2a, gbf_buf1_ready, gbf_buf2_ready, gbf_data_avail, fill_busy);
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || fill_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_held_need_latency: got in_ready=%b busy=%b, want 0 0",
                  in_ready, fill_busy);
      end
      @(negedge clk);
      do_fill(1, 32, 0, 0, -1);
      @(negedge clk);
      do_fill(2, 32, 0, 32, -1);
      gbf1_need_data = 1'b0;
      gbf2_need_data = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_gaps;
      fill_words = 6'd4;
      request(1);
      do_fill(1, 4, 1, 100, -1);
   endtask

   task automatic test_len_clamp;
      fill_words = 6'd0;
      request(2);
      do_fill(2, 32, 2, 0, -1);
      fill_words = 6'd40;
      request(1);
      do_fill(1, 32, 2, 0, -1);
   endtask

   task automatic test_cross_request;
      fill_words = 6'd8;
      request(2);
      do_fill(2, 8, 2, 0, 3);
      @(negedge clk);
      do_fill(1, 8, 0, 200, -1);
   endtask

   task automatic test_finish;
      fill_words = 6'd32;
      gbf1_need_data = 1'b1;
      @(negedge clk);
      m_ready1 = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_data = DW'(i);
         @(negedge clk);
      end
      finish = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      finish = 1'b0;
      m_ready1 = 1'b0; m_ready2 = 1'b0; m_avail = 1'b0;
      checks++;
      if (in_ready !== 0 || fill_busy !== 0 || en1a !== 0 || we1a !== 0 || en2a !== 0 ||
          we2a !== 0 || gbf_buf1_ready !== 0 || gbf_buf2_ready !== 0 || gbf_data_avail !== 0) begin
         errors++;
         $display("FAIL finish_flush: got rdy=%b busy=%b we=%b%b r=%b%b av=%b, want all 0",
                  in_ready, fill_busy, we1a, we2a, gbf_buf1_ready, gbf_buf2_ready, gbf_data_avail);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (fill_busy !== 0 || in_ready !== 0 || we1a !== 0 || we2a !== 0) begin
            errors++;
            $display("FAIL finish_held_need cyc%0d: got busy=%b rdy=%b we=%b%b, want 0 0 00",
                     i, fill_busy, in_ready, we1a, we2a);
         end
      end
      in_valid = 1'b0;
      gbf1_need_data = 1'b0;
      @(negedge clk);
      fill_words = 6'd5;
      request(1);
      do_fill(1, 5, 2, 0, -1);
   endtask

   task automatic test_reset_mid_fill;
      fill_words = 6'd6;
      gbf2_need_data = 1'b1;
      @(negedge clk);
      m_ready2 = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data = DW'(i + 7);
         @(negedge clk);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      m_ready1 = 1'b0; m_ready2 = 1'b0; m_avail = 1'b0;
      checks++;
      if (in_ready !== 0 || en1a !== 0 || we1a !== 0 || addr1a !== '0 || w_data1a !== '0 ||
          en2a !== 0 || we2a !== 0 || addr2a !== '0 || w_data2a !== '0 ||
          gbf_buf1_ready !== 0 || gbf_buf2_ready !== 0 || gbf_data_avail !== 0 ||
          fill_busy !== 0) begin
         errors++;
         $display("FAIL reset_mid_fill: got rdy=%b we=%b%b a2=%0d r=%b%b av=%b busy=%b, want all 0",
                  in_ready, we1a, we2a, addr2a, gbf_buf1_ready, gbf_buf2_ready,
                  gbf_data_avail, fill_busy);
      end
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (fill_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_refill_latency: got busy=%b, want 0", fill_busy);
      end
      @(negedge clk);
      do_fill(2, 6, 2, 0, -1);
      gbf2_need_data = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_gaps();
      test_len_clamp();
      test_cross_request();
      test_finish();
      test_reset_mid_fill();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
